// File: rtl/loop_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loop_unit_pkg
// Purpose  : Shared types and constants for the BeeF loop-control slice:
//            program counter / op_code types, bracket op codes, loop FSM
//            states and the ALU increment used to form return addresses.
// Revision : 1.0 - initial release
// ============================================================================
package loop_unit_pkg;

    typedef logic [15:0] PROGRAM_COUNTER;
    typedef logic [8:0]  op_code;

    // Bracket op codes use the ASCII value of the source character.
    localparam op_code OP_LOOP_OPEN  = 9'h05B;  // '['
    localparam op_code OP_LOOP_CLOSE = 9'h05D;  // ']'

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SKIP  = 2'd1,
        FAULT = 2'd2
    } LOOP_STATE;

    typedef enum logic [1:0] {
        ALU_INC  = 2'd0,
        ALU_DEC  = 2'd1,
        ALU_PASS = 2'd2
    } alu_op_t;

    // Program-counter ALU; arithmetic wraps modulo 2^16.
    function automatic PROGRAM_COUNTER alu(input alu_op_t op, input PROGRAM_COUNTER a);
        case (op)
            ALU_INC: return a + 16'd1;
            ALU_DEC: return a - 16'd1;
            default: return a;
        endcase
    endfunction

endpackage : loop_unit_pkg
`default_nettype wire

// File: rtl/loop_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : loop_unit_if
// Purpose  : Fetch/execute side bus of the loop unit.
//            master : loop_unit (consumes instruction/pc/cell_zero/exec_ready,
//                     drives pc_write/pc_src/pc_loaded/exec_valid/
//                     loop_depth/fault)
//            slave  : fetch/execute environment (opposite directions)
// Revision : 1.0 - initial release
// ============================================================================
interface loop_unit_if #(
    parameter int STACK_DEPTH = 16
) ();
    import loop_unit_pkg::*;

    op_code                         instruction;
    PROGRAM_COUNTER                 pc;
    logic                           cell_zero;
    logic                           exec_ready;
    logic                           pc_write;
    logic                           pc_src;
    PROGRAM_COUNTER                 pc_loaded;
    logic                           exec_valid;
    logic [$clog2(STACK_DEPTH):0]   loop_depth;
    logic                           fault;

    modport master (
        input  instruction, pc, cell_zero, exec_ready,
        output pc_write, pc_src, pc_loaded, exec_valid, loop_depth, fault
    );

    modport slave (
        output instruction, pc, cell_zero, exec_ready,
        input  pc_write, pc_src, pc_loaded, exec_valid, loop_depth, fault
    );

endinterface : loop_unit_if
`default_nettype wire

// File: rtl/loop_unit_stack.sv
`default_nettype none
// ============================================================================
// Module   : loop_stack
// Purpose  : LIFO of loop return addresses.
// Ports    : clk, reset_n (async active-low), push_i/pop_i (ignored when
//            full/empty), data_i (value to push), top_o (most recent entry),
//            full_o, empty_o, count_o (occupancy, 0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module loop_stack #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16
) (
    input  wire logic                       clk,
    input  wire logic                       reset_n,
    input  wire logic                       push_i,
    input  wire logic                       pop_i,
    input  wire logic [DATA_W-1:0]          data_i,
    output logic      [DATA_W-1:0]          top_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic      [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        sp_q, sp_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]      top_idx;

    assign full_o  = (sp_q == (AW+1)'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign count_o = sp_q;

    // Index wraps to DEPTH-1 when empty; top_o is then meaningless but harmless.
    assign top_idx = sp_q[AW-1:0] - 1'b1;
    assign top_o   = mem_q[top_idx];

    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage needs no reset: entries above sp are never observed.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[sp_q[AW-1:0]] <= data_i;
        end
    end

endmodule : loop_stack
`default_nettype wire

// File: rtl/loop_unit.sv
`default_nettype none
// ============================================================================
// Module   : loop_unit
// Purpose  : Loop-bracket controller between fetch and execute. Maintains a
//            return-address stack for '[' / ']', forward-skips loop bodies
//            entered with a zero cell, squashes skipped instructions and
//            steers the fetch pc.
// Ports    : clk, reset_n (async active-low)
//            bus (loop_unit_if.master): instruction, pc, cell_zero,
//            exec_ready in; pc_write, pc_src, pc_loaded, exec_valid,
//            loop_depth, fault out
// Revision : 1.0 - initial release
// ============================================================================
module loop_unit
    import loop_unit_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int SKIP_W      = 8
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    loop_unit_if.master     bus
);
    LOOP_STATE          state_q, state_d;
    logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d;

    logic               push, pop;
    logic               stk_full, stk_empty;
    PROGRAM_COUNTER     stk_top, ret_addr;
    logic [$clog2(STACK_DEPTH):0] stk_count;

    logic               pc_write, pc_src, exec_valid;
    logic               is_open, is_close;

    assign is_open  = (bus.instruction == OP_LOOP_OPEN);
    assign is_close = (bus.instruction == OP_LOOP_CLOSE);
    assign ret_addr = alu(ALU_INC, bus.pc);

    loop_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (16)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (ret_addr),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .count_o (stk_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            skip_cnt_q <= '0;
        end else if (bus.exec_ready) begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        push       = 1'b0;
        pop        = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        exec_valid = 1'b0;

        case (state_q)
            RUN: begin
                pc_write   = 1'b1;
                exec_valid = 1'b1;
                if (is_open) begin
                    if (bus.cell_zero) begin
                        exec_valid = 1'b0;
                        skip_cnt_d = SKIP_W'(1);
                        state_d    = SKIP;
                    end else if (stk_full) begin
                        pc_write   = 1'b0;
                        exec_valid = 1'b0;
                        state_d    = FAULT;
                    end else begin
                        push = 1'b1;
                    end
                end else if (is_close) begin
                    if (stk_empty) begin
                        pc_write   = 1'b0;
                        exec_valid = 1'b0;
                        state_d    = FAULT;
                    end else if (bus.cell_zero) begin
                        pop = 1'b1;
                    end else begin
                        pc_src = 1'b1;
                    end
                end
            end

            SKIP: begin
                pc_write = 1'b1;
                if (is_open) begin
                    if (&skip_cnt_q) begin
                        pc_write = 1'b0;
                        state_d  = FAULT;
                    end else begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                    end
                end else if (is_close) begin
                    skip_cnt_d = skip_cnt_q - 1'b1;
                    if (skip_cnt_q == SKIP_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end

            default: begin
                // FAULT: everything held off until reset.
            end
        endcase

        if (!bus.exec_ready) begin
            pc_write   = 1'b0;
            exec_valid = 1'b0;
            push       = 1'b0;
            pop        = 1'b0;
        end

        // Fetch needs pc_write high during reset to load pc=0.
        if (!reset_n) begin
            pc_write   = 1'b1;
            pc_src     = 1'b0;
            exec_valid = 1'b0;
            push       = 1'b0;
            pop        = 1'b0;
        end
    end

    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.exec_valid = exec_valid;
    assign bus.pc_loaded  = reset_n ? stk_top : '0;
    assign bus.loop_depth = stk_count;
    assign bus.fault      = (state_q == FAULT);

endmodule : loop_unit
`default_nettype wire

// File: doc/loop_unit.md
Name: loop_unit

Overview:
- Control-side partner of the fetch stage.
- Consumes the fetched instruction and its pc, and drives the fetch stage's pc_src, pc_loaded and pc_write.
- Resolves BeeF loop brackets: keeps a return-address stack for '[' / ']', and runs a forward-skip state machine when a '[' is entered with a zero cell.
- Sits between fetch and execute; squashes execution of skipped instructions via exec_valid.

Parameters:
- STACK_DEPTH, 16, number of nested open loops held; must be a power of two, at least 2.
- SKIP_W, 8, width of the skip nesting counter; maximum skip depth is 2^SKIP_W-1.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- instruction  in  9  op_code from fetch, valid in the same cycle as pc (combinational ROM)
- pc  in  16  current PROGRAM_COUNTER from fetch
- cell_zero  in  1  current data cell == 0, valid in the same cycle as instruction
- exec_ready  in  1  execute stage accepts the instruction this cycle
- pc_write  out  1  fetch pc register enable
- pc_src  out  1  0 = pc+1, 1 = pc_loaded
- pc_loaded  out  16  jump target
- exec_valid  out  1  instruction must be executed (0 = squashed)
- loop_depth  out  $clog2(STACK_DEPTH)+1  current stack occupancy
- fault  out  1  sticky error (overflow, underflow or skip overflow)

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=RUN, sp=0, skip_cnt=0, fault=0.
  - While reset_n is low: pc_write=1, pc_src=0, pc_loaded=0, exec_valid=0. pc_write is held high so the fetch reset mux can load pc=0.
- States: RUN, SKIP, FAULT. All outputs are combinational from state, instruction, cell_zero, exec_ready and stack top. State updates on the rising clk edge only when exec_ready=1.
- Stall: exec_ready=0 gives pc_write=0, exec_valid=0, no stack or counter change, in any state.
- RUN, non-bracket op: pc_write=1, pc_src=0, exec_valid=1.
- RUN, '[' with cell_zero=0:
  - Push pc+1 (16-bit wrap, 0xFFFF+1=0x0000); fall through; exec_valid=1.
  - If sp==STACK_DEPTH: no push, fault=1, next=FAULT, pc_write=0.
- RUN, '[' with cell_zero=1: no push; skip_cnt=1; next=SKIP; pc_src=0; exec_valid=0.
- RUN, ']' with empty stack: fault=1, next=FAULT, pc_write=0.
- RUN, ']' with cell_zero=1: pop; pc_src=0; exec_valid=1.
- RUN, ']' with cell_zero=0: no pop; pc_src=1; pc_loaded=stack top; exec_valid=1. Jump latency is one cycle: the target's instruction is presented next cycle.
- SKIP (every instruction has exec_valid=0, pc_write=1, pc_src=0; stack untouched; cell_zero ignored):
  - '[': skip_cnt+1. If skip_cnt was all-ones: fault, next=FAULT.
  - ']' with skip_cnt>1: skip_cnt-1.
  - ']' with skip_cnt==1: skip_cnt=0, next=RUN. The instruction after the matching ']' executes normally.
- FAULT: pc_write=0, exec_valid=0, fault=1; left only by reset.
- Single-cycle decision: there is no simultaneous push and pop; each instruction performs at most one stack op.
- Reset asserted mid-SKIP or mid-stall: state and stack clear immediately; no partial update on the next edge.

Decomposition:
- Package definitions:
  - OP_LOOP_OPEN and OP_LOOP_CLOSE as op_code values.
  - LOOP_STATE enum (RUN, SKIP, FAULT).
  - Reuse PROGRAM_COUNTER and op_code.
- Sub-module loop_stack (push, pop, top, full, empty, count) holds the LIFO storage. The next-pc mux and FSM stay in loop_unit. The pc+1 for the push reuses the existing alu with ALU_INC.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with exec_ready=1 -> pc_write=1, exec_valid=0, loop_depth=0, fault=0. After release, first op at pc=0 gives exec_valid=1.
- Taken loop: '[' at pc=0x0010 with cell_zero=0 -> push 0x0011, loop_depth=1. ']' at 0x0014 with cell_zero=0 -> pc_src=1, pc_loaded=0x0011. Second ']' with cell_zero=1 -> pop, loop_depth=0, pc_src=0.
- Skip nested: '[' at 0x0020 with cell_zero=1, then "[ + ] ]" -> all four squashed (exec_valid=0), skip_cnt goes 1,2,2,1,0. Op at 0x0025 executes; loop_depth unchanged.
- Stall: exec_ready=0 for 2 cycles during SKIP with skip_cnt=2 -> pc_write=0, skip_cnt stays 2. Resumes correctly when exec_ready returns to 1.
- Overflow: STACK_DEPTH=16 taken '[' then a 17th -> fault=1, pc_write=0 thereafter, loop_depth=16. Cleared only by reset_n.
- Underflow and wrap: ']' with loop_depth=0 -> fault=1. Separately, '[' at pc=0xFFFF with cell_zero=0 pushes 0x0000.
